sr_latch_framed: RTL
====================

SR_LATCH_FRAMED -- requirements
Module: sr_latch_framed

Interface
REQ-001 SHALL have parameter N, default 8, data bits per channel per frame (N >= 2).
REQ-002 SHALL have parameter CH, default 1, number of parallel serial lanes sharing sclk/rclk (CH >= 1).
REQ-003 SHALL have parameter MSB_FIRST, default 0; 0 = first bit shifted ends at bit 0, 1 = first bit shifted ends at bit N-1.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sclk  input  1  one-cycle shift strobe, synchronous to clk.
REQ-007 SHALL have port rclk  input  1  one-cycle latch (register-clock) strobe, synchronous to clk.
REQ-008 SHALL have port ser_in  input  CH  serial data, bit c feeds channel c.
REQ-009 SHALL have port err_clr  input  1  synchronous clear of sticky error flags.
REQ-010 SHALL have port par_out  output  CH*N  latched parallel data, channel c in bits [c*N+N-1 : c*N].
REQ-011 SHALL have port upd  output  1  one-cycle pulse, high in the cycle par_out takes new data.
REQ-012 SHALL have port frame_err  output  1  sticky: latch attempted with wrong bit count or colliding strobes.
REQ-013 SHALL have port parity_err  output  1  sticky: latch attempted with bad parity (0 when parity compiled out).

Function
REQ-014 SHALL define FRAME = N (parity out) or N+1 (parity in); each channel's shift register is FRAME bits wide.
REQ-015 SHALL, on sclk, shift ser_in[c] into every channel: MSB_FIRST=0 inserts at top and shifts down; MSB_FIRST=1 inserts at bit 0 and shifts up.
REQ-016 SHALL keep a bit counter with states IDLE (0), SHIFTING (1..FRAME-1), FULL (=FRAME), OVERRUN (>FRAME, saturating at FRAME+1).
REQ-017 SHALL increment the counter on each sclk; it never wraps.
REQ-018 SHALL, on rclk in FULL with parity OK, copy the data bits of all channels to par_out and assert upd for exactly that cycle.
REQ-019 SHALL, on rclk in IDLE, SHIFTING or OVERRUN, leave par_out unchanged, keep upd low and set frame_err.
REQ-020 SHALL return the counter to IDLE on every accepted rclk regardless of outcome; the shift register content is retained.
REQ-021 SHALL give sclk priority when sclk and rclk coincide: shift performed, latch dropped, frame_err set.
REQ-022 SHALL latch par_out on the same clk edge that samples rclk (latency 1 edge, no pipeline).
REQ-023 SHALL clear frame_err and parity_err on err_clr; a new error event in the same cycle wins (flag stays set).

Reset
REQ-024 SHALL, while clr is high, asynchronously force shift registers, par_out, counter (IDLE), upd, frame_err and parity_err to 0.
REQ-025 SHALL treat clr mid-frame as frame abort; the next frame starts from IDLE after release.

Configuration
REQ-026 SHALL compile per-frame odd parity when macro SR_LATCH_PARITY_EN is defined: FRAME = N+1, last bit shifted is parity.
REQ-027 SHALL, with SR_LATCH_PARITY_EN, require XOR of the N data bits and parity bit = 1 for every channel; any failure blocks the latch, keeps upd low and sets parity_err.
REQ-028 SHALL, without SR_LATCH_PARITY_EN, use FRAME = N, no parity logic, parity_err tied to 0.

Structure
REQ-029 SHALL place counter-state encoding and the FRAME width helper ($clog2(FRAME+2)) in shared package sr_latch_pkg.
REQ-030 SHALL implement one channel (shift register plus parity check) as sub-module sr_lane, instantiated CH times by generate.

Verification
REQ-031 SHALL cover N=8, CH=1, MSB_FIRST=0: 8 sclk with bits 1,0,1,1,0,0,0,0 then rclk -> par_out=8'h0D, upd one cycle, no errors.
REQ-032 SHALL cover MSB_FIRST=1, same bit sequence -> par_out=8'hB0.
REQ-033 SHALL cover CH=2, 7 sclk then rclk -> par_out unchanged, frame_err=1; err_clr -> frame_err=0.
REQ-034 SHALL cover sclk and rclk in the same cycle at count 8 -> shift occurs, no upd, frame_err=1, counter OVERRUN.
REQ-035 SHALL cover parity build, data 8'hA5 with parity bit 0 -> no update, parity_err=1; parity bit 1 -> par_out=8'hA5.
REQ-036 SHALL cover clr pulse after 4 sclk -> all outputs 0; a full 8-bit frame then latches correctly.

Source files
------------

// File: rtl/sr_latch_pkg.sv
// Shared types and sizing helpers for the framed serial-to-parallel latch.
// SR_LATCH_PARITY_EN adds one odd-parity bit to every frame.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_SHIFTING,
    CNT_FULL,
    CNT_OVERRUN
  } cnt_state_t;

`ifdef SR_LATCH_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  function automatic int frame_len(input int n);
    return n + PAR_BITS;
  endfunction

  function automatic int cnt_width(input int frame);
    return $clog2(frame + 2);
  endfunction

endpackage

// File: rtl/sr_lane.sv
// One serial lane: frame-wide shift register plus odd-parity check.
// SR_LATCH_PARITY_EN enables the parity bit and its check.
module sr_lane
  import sr_latch_pkg::*;
#(
  parameter int N         = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         shift,
  input  logic         din,
  output logic [N-1:0] data,
  output logic         par_ok
);

  localparam int FRAME = frame_len(N);

  logic [FRAME-1:0] sr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr <= '0;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        sr <= {sr[FRAME-2:0], din};
      end else begin
        sr <= {din, sr[FRAME-1:1]};
      end
    end
  end

  // The parity bit is shifted last, so it sits opposite the data start.
  if (MSB_FIRST != 0) begin : g_msb
    assign data = sr[FRAME-1 -: N];
  end else begin : g_lsb
    assign data = sr[N-1:0];
  end

`ifdef SR_LATCH_PARITY_EN
  assign par_ok = ^sr;
`else
  assign par_ok = 1'b1;
`endif

endmodule

// File: rtl/sr_latch_framed.sv
// Multi-lane framed shift register with bit-count checked output latch.
// SR_LATCH_PARITY_EN adds per-frame odd parity and parity_err.
module sr_latch_framed
  import sr_latch_pkg::*;
#(
  parameter int N         = 8,
  parameter int CH        = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sclk,
  input  logic          rclk,
  input  logic [CH-1:0] ser_in,
  input  logic          err_clr,
  output logic [CH*N-1:0] par_out,
  output logic          upd,
  output logic          frame_err,
  output logic          parity_err
);

  localparam int FRAME = frame_len(N);
  localparam int CW    = cnt_width(FRAME);
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME);

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  cnt_state_t      st;
  logic [CH*N-1:0] data;
  logic [CH-1:0]   ok;
  logic            par_good;
  logic            latch_try;
  logic            latch_ok;
  logic            frame_ev;

  for (genvar c = 0; c < CH; c++) begin : g_lane
    sr_lane #(
      .N         (N),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk    (clk),
      .clr    (clr),
      .shift  (sclk),
      .din    (ser_in[c]),
      .data   (data[c*N +: N]),
      .par_ok (ok[c])
    );
  end

  assign par_good = &ok;

  always_comb begin
    st = CNT_SHIFTING;
    if (cnt == '0) begin
      st = CNT_IDLE;
    end else if (cnt == FULL_CNT) begin
      st = CNT_FULL;
    end else if (cnt > FULL_CNT) begin
      st = CNT_OVERRUN;
    end
  end

  // sclk wins a collision: the latch request is dropped, not accepted.
  always_comb begin
    cnt_nxt   = cnt;
    latch_try = 1'b0;
    frame_ev  = 1'b0;
    if (sclk) begin
      if (st != CNT_OVERRUN) begin
        cnt_nxt = cnt + 1'b1;
      end
      frame_ev = rclk;
    end else if (rclk) begin
      cnt_nxt = '0;
      if (st == CNT_FULL) begin
        latch_try = 1'b1;
      end else begin
        frame_ev = 1'b1;
      end
    end
  end

  assign latch_ok = latch_try & par_good;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt       <= '0;
      par_out   <= '0;
      upd       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      upd       <= latch_ok;
      frame_err <= (frame_err & ~err_clr) | frame_ev;
      if (latch_ok) begin
        par_out <= data;
      end
    end
  end

`ifdef SR_LATCH_PARITY_EN
  logic parity_ev;

  assign parity_ev = latch_try & ~par_good;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= (parity_err & ~err_clr) | parity_ev;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
